// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - data-memory access sequencer between the dmem_* port group and a wait-state SRAM
// Optional feature macro: DMEM_BRIDGE_ALIGN_CHECK_EN (misaligned requests complete at once with dmem_err).
module dmem_bridge #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned MEM_AW      = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dmem_en,
   input  logic              dmem_wen,
   input  logic [12:0]       dmem_addr,
   input  logic [31:0]       dmem_wdata,
   input  logic [1:0]        mem_size,
   output logic [31:0]       dmem_rdata,
   output logic              dmem_ready,
   output logic              dmem_busy,
   output logic              dmem_err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPT,
      S_DONE,
      S_HOLD
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wen_q;
   logic       err_q;
   logic       mis_req;

`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
   assign mis_req = ((mem_size == 2'b10) && (dmem_addr[1:0] != 2'b00)) ||
                    ((mem_size == 2'b01) && dmem_addr[0]);
`else
   logic unused_align;
   assign unused_align = ^{mem_size, dmem_addr[1:0]};
   assign mis_req      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (dmem_en) begin
               state_d = mis_req ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d = WS;
            if (WS != 4'd0) begin
               state_d = S_WAIT;
            end else begin
               state_d = wen_q ? S_DONE : S_CAPT;
            end
         end
         S_WAIT: begin
            // Counter was loaded with WAIT_STATES, so leaving at 1 gives exactly that many cycles here.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = wen_q ? S_DONE : S_CAPT;
            end
         end
         S_CAPT: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = dmem_en ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (!dmem_en) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         wen_q      <= 1'b0;
         err_q      <= 1'b0;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'd0;
         dmem_rdata <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == S_IDLE) && dmem_en) begin
            wen_q     <= dmem_wen;
            err_q     <= mis_req;
            mem_addr  <= dmem_addr[MEM_AW+1:2];
            mem_wdata <= dmem_wdata;
         end
         // ISSUE is only reachable from IDLE, so the live dmem_wen is the value being latched.
         mem_cs <= (state_d == S_ISSUE);
         mem_we <= (state_d == S_ISSUE) && dmem_wen;
         if (state_q == S_CAPT) begin
            dmem_rdata <= mem_rdata;
         end
      end
   end

   assign dmem_ready = (state_q == S_DONE);
   assign dmem_busy  = (state_q != S_IDLE);
   assign dmem_err   = err_q && (state_q == S_DONE);

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - self-checking bench for dmem_bridge at WAIT_STATES 0, 1 and 3 in lockstep
module tb_dmem_bridge;
   localparam int NI = 3;
   localparam int AW = 11;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   dmem_en;
   logic                   dmem_wen;
   logic [12:0]            dmem_addr;
   logic [31:0]            dmem_wdata;
   logic [1:0]             mem_size;
   logic [NI-1:0][31:0]    rdata_a;
   logic [NI-1:0][31:0]    mwdata_a;
   logic [NI-1:0][AW-1:0]  maddr_a;
   logic [NI-1:0]          rdy_a, busy_a, err_a, cs_a, we_a;

   int ws [NI] = '{0, 1, 3};
   int edge_cnt = 0;
   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [31:0] init_word(input int a);
      if (a == 4) return 32'hDEADBEEF;
      return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
      logic [31:0]   sram [2**AW];
      bit            written [2**AW];
      logic          rd_pend = 1'b0;
      int            rd_dly = 0;
      logic [AW-1:0] rd_a = '0;
      logic [31:0]   mem_rdata;

      always @(posedge clk) begin
         if (cs_a[g] === 1'b1 && we_a[g] === 1'b1) begin
            sram[maddr_a[g]]    <= mwdata_a[g];
            written[maddr_a[g]] <= 1'b1;
         end
         if (cs_a[g] === 1'b1 && we_a[g] === 1'b0) begin
            rd_pend <= 1'b1;
            rd_dly  <= W;
            rd_a    <= maddr_a[g];
         end else if (rd_dly > 0) begin
            rd_dly <= rd_dly - 1;
         end else begin
            rd_pend <= 1'b0;
         end
      end

      // Junk outside the single valid cycle so a mistimed capture is visible.
      always_comb begin
         mem_rdata = 32'hBADC0DE0 ^ 32'(edge_cnt);
         if (rd_pend && rd_dly == 0) begin
            mem_rdata = written[rd_a] ? sram[rd_a] : init_word(int'(rd_a));
         end
      end

      dmem_bridge #(.WAIT_STATES(W), .MEM_AW(AW)) u_dut (
         .clk(clk), .rst(rst), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
         .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mem_size(mem_size),
         .dmem_rdata(rdata_a[g]), .dmem_ready(rdy_a[g]), .dmem_busy(busy_a[g]),
         .dmem_err(err_a[g]), .mem_cs(cs_a[g]), .mem_we(we_a[g]),
         .mem_addr(maddr_a[g]), .mem_wdata(mwdata_a[g]), .mem_rdata(mem_rdata)
      );
   end

   int            cs_cnt [NI], rdy_cnt [NI], cs_edge [NI], rdy_edge [NI], err_stray [NI];
   logic          cs_we_s [NI], rdy_err_s [NI];
   logic [AW-1:0] cs_addr_s [NI];
   logic [31:0]   cs_wd_s [NI], rdy_rd_s [NI];

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (cs_a[g] === 1'b1) begin
            cs_cnt[g]    <= cs_cnt[g] + 1;
            cs_edge[g]   <= edge_cnt;
            cs_we_s[g]   <= we_a[g];
            cs_addr_s[g] <= maddr_a[g];
            cs_wd_s[g]   <= mwdata_a[g];
         end
         if (rdy_a[g] === 1'b1) begin
            rdy_cnt[g]   <= rdy_cnt[g] + 1;
            rdy_edge[g]  <= edge_cnt;
            rdy_err_s[g] <= err_a[g];
            rdy_rd_s[g]  <= rdata_a[g];
         end
         if (err_a[g] === 1'b1 && rdy_a[g] !== 1'b1) err_stray[g] <= err_stray[g] + 1;
      end
   end

   logic [31:0] ref_mem [int];
   logic [31:0] exp_rdata [NI];

   function automatic logic [31:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic do_access(input string name, input logic wen, input logic [12:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz, input int hold);
      int cs0 [NI];
      int rd0 [NI];
      int t0, ncyc, wa, e_cs, e_cyc;
      logic mis, e_err;
      logic [31:0] e_rd;
      for (int g = 0; g < NI; g++) begin
         cs0[g] = cs_cnt[g];
         rd0[g] = rdy_cnt[g];
      end
      mis = 1'b0;
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
      mis = ((sz == 2'b10) && (addr[1:0] != 2'b00)) || ((sz == 2'b01) && addr[0]);
`endif
      wa = int'(addr[12:2]);
      @(posedge clk); #1;
      t0 = edge_cnt;
      dmem_en = 1'b1; dmem_wen = wen; dmem_addr = addr; dmem_wdata = wd; mem_size = sz;
      ncyc = (hold + 1 > 7) ? hold + 1 : 7;
      for (int c = 1; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (c >= hold) dmem_en = 1'b0;
         dmem_wen = 1'($urandom_range(0, 1));
         dmem_addr = 13'($urandom);
         dmem_wdata = $urandom;
         mem_size = 2'($urandom);
         if (c == 1) begin
            for (int g = 0; g < NI; g++) begin
               cmp_cnt++;
               if (busy_a[g] !== 1'b1) begin
                  err_cnt++;
                  $display("FAIL %s[W%0d] busy: got %b want 1", name, ws[g], busy_a[g]);
               end
            end
         end
      end
      @(negedge clk); #1;
      for (int g = 0; g < NI; g++) begin
         e_cs  = mis ? 0 : 1;
         e_cyc = mis ? 1 : (wen ? 2 + ws[g] : 3 + ws[g]);
         e_err = mis;
         e_rd  = (mis || wen) ? exp_rdata[g] : ref_rd(wa);
         cmp_cnt++;
         if (cs_cnt[g] - cs0[g] !== e_cs) begin
            err_cnt++;
            $display("FAIL %s[W%0d] cs_pulses: got %0d want %0d", name, ws[g], cs_cnt[g] - cs0[g], e_cs);
         end
         cmp_cnt++;
         if (rdy_cnt[g] - rd0[g] !== 1) begin
            err_cnt++;
            $display("FAIL %s[W%0d] ready_pulses: got %0d want 1", name, ws[g], rdy_cnt[g] - rd0[g]);
         end
         cmp_cnt++;
         if (rdy_edge[g] - t0 !== e_cyc) begin
            err_cnt++;
            $display("FAIL %s[W%0d] ready_cycle: got %0d want %0d", name, ws[g], rdy_edge[g] - t0, e_cyc);
         end
         cmp_cnt++;
         if (rdy_err_s[g] !== e_err) begin
            err_cnt++;
            $display("FAIL %s[W%0d] err: got %b want %b", name, ws[g], rdy_err_s[g], e_err);
         end
         cmp_cnt++;
         if (rdy_rd_s[g] !== e_rd) begin
            err_cnt++;
            $display("FAIL %s[W%0d] rdata: got %h want %h", name, ws[g], rdy_rd_s[g], e_rd);
         end
         if (!mis) begin
            cmp_cnt++;
            if (cs_edge[g] - t0 !== 1) begin
               err_cnt++;
               $display("FAIL %s[W%0d] cs_cycle: got %0d want 1", name, ws[g], cs_edge[g] - t0);
            end
            cmp_cnt++;
            if (cs_addr_s[g] !== addr[12:2] || cs_we_s[g] !== wen) begin
               err_cnt++;
               $display("FAIL %s[W%0d] addr/we: got %h/%b want %h/%b", name, ws[g],
                        cs_addr_s[g], cs_we_s[g], addr[12:2], wen);
            end
            if (wen) begin
               cmp_cnt++;
               if (cs_wd_s[g] !== wd) begin
                  err_cnt++;
                  $display("FAIL %s[W%0d] wdata: got %h want %h", name, ws[g], cs_wd_s[g], wd);
               end
            end
         end
      end
      if (!mis) begin
         if (wen) ref_mem[wa] = wd;
         else for (int g = 0; g < NI; g++) exp_rdata[g] = ref_rd(wa);
      end
   endtask

   task automatic check_zero(input string name);
      for (int g = 0; g < NI; g++) begin
         cmp_cnt++;
         if ({rdata_a[g], rdy_a[g], busy_a[g], err_a[g], cs_a[g], we_a[g], maddr_a[g], mwdata_a[g]} !== '0) begin
            err_cnt++;
            $display("FAIL %s[W%0d] outputs_zero: got rdata=%h rdy=%b busy=%b err=%b cs=%b we=%b addr=%h wd=%h want all 0",
                     name, ws[g], rdata_a[g], rdy_a[g], busy_a[g], err_a[g], cs_a[g], we_a[g], maddr_a[g], mwdata_a[g]);
         end
      end
   endtask

   task automatic test_reset();
      int cs0 [NI];
      rst = 1'b1; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_wdata = '0; mem_size = 2'b10;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
         cs0[g] = cs_cnt[g];
         exp_rdata[g] = 32'd0;
      end
      check_zero("reset");
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check_zero("idle");
      end
      for (int g = 0; g < NI; g++) begin
         cmp_cnt++;
         if (cs_cnt[g] !== cs0[g]) begin
            err_cnt++;
            $display("FAIL idle[W%0d] cs_pulses: got %0d want 0", ws[g], cs_cnt[g] - cs0[g]);
         end
      end
   endtask

   task automatic test_read_basic();
      do_access("read_beef", 1'b0, 13'h0010, 32'h0, 2'b10, 1);
   endtask

   task automatic test_write_readback();
      do_access("write_w0", 1'b1, 13'h0020, 32'h12345678, 2'b10, 1);
      do_access("readback", 1'b0, 13'h0020, 32'h0, 2'b10, 1);
   endtask

   task automatic test_hold();
      do_access("held_en", 1'b0, 13'h0010, 32'h0, 2'b10, 10);
      do_access("after_hold", 1'b0, 13'h0020, 32'h0, 2'b10, 1);
   endtask

   task automatic test_reset_mid();
      int rd0 [NI];
      for (int g = 0; g < NI; g++) rd0[g] = rdy_cnt[g];
      @(posedge clk); #1;
      dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = 13'h0044; mem_size = 2'b10;
      @(posedge clk); #1;
      dmem_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("after_rst");
      @(negedge clk); #1;
      for (int g = 0; g < NI; g++) begin
         cmp_cnt++;
         // Only the zero-wait instance finishes (cycle 3) before the reset edge.
         if (rdy_cnt[g] - rd0[g] !== ((ws[g] == 0) ? 1 : 0)) begin
            err_cnt++;
            $display("FAIL rst_mid[W%0d] ready_pulses: got %0d want %0d", ws[g],
                     rdy_cnt[g] - rd0[g], (ws[g] == 0) ? 1 : 0);
         end
         exp_rdata[g] = 32'd0;
      end
      do_access("read_after_rst", 1'b0, 13'h0044, 32'h0, 2'b10, 1);
   endtask

   task automatic test_align();
      do_access("word_0006", 1'b0, 13'h0006, 32'h0, 2'b10, 1);
      do_access("half_0006", 1'b0, 13'h0006, 32'h0, 2'b01, 1);
      do_access("byte_0007_wr", 1'b1, 13'h0007, 32'hA5A55A5A, 2'b00, 1);
      do_access("half_0005_wr", 1'b1, 13'h0005, 32'h0F0F1234, 2'b01, 1);
      do_access("word_0004", 1'b0, 13'h0004, 32'h0, 2'b10, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_access("random", 1'($urandom_range(0, 1)), 13'($urandom_range(0, 31)),
                   $urandom, 2'($urandom_range(0, 2)), $urandom_range(1, 3));
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_readback();
      test_hold();
      test_reset_mid();
      test_align();
      test_random();
      for (int g = 0; g < NI; g++) begin
         cmp_cnt++;
         if (err_stray[g] !== 0) begin
            err_cnt++;
            $display("FAIL stray_err[W%0d]: got %0d cycles want 0", ws[g], err_stray[g]);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory access sequencer between the multicycle datapath's `dmem_*` port group and a synchronous single-port data SRAM with a configurable number of wait states. It latches one request per `dmem_en` assertion, drives the SRAM for exactly one strobe cycle, and counts out the wait states. For reads it captures the returned word, then pulses `dmem_ready` so the controller can leave its MEM state.

## Interface
- `WAIT_STATES`, default 1: extra SRAM cycles between the strobe and valid read data. Legal range 0..15.
- `MEM_AW`, default 11: SRAM word-address width, taken from byte-address bits [12:2].
- `clk` input 1: sole clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `dmem_en` input 1: request level from the datapath.
- `dmem_wen` input 1: 0 = read, 1 = write. Sampled with `dmem_en`.
- `dmem_addr` input 13: byte address.
- `dmem_wdata` input 32: full store word, already merged by the datapath.
- `mem_size` input 2: access size, 00 = byte, 01 = half, 10 = word. Used only for the alignment check.
- `dmem_rdata` output 32: last captured read word. Held until the next read completes.
- `dmem_ready` output 1: one-cycle completion pulse.
- `dmem_busy` output 1: high in every state except IDLE.
- `dmem_err` output 1: misalignment flag. Valid only in the `dmem_ready` cycle.
- `mem_cs` output 1: SRAM chip select. Registered.
- `mem_we` output 1: SRAM write enable. Registered. Qualified by `mem_cs`.
- `mem_addr` output MEM_AW: word address. Registered.
- `mem_wdata` output 32: write data. Registered.
- `mem_rdata` input 32: SRAM read data. Valid during cycle T+1+WAIT_STATES when `mem_cs` was high in cycle T.

## Operation
- The FSM has six states: IDLE, ISSUE, WAIT, CAPT, DONE, HOLD.
- **IDLE:** when `dmem_en`=1, latch `dmem_wen`, `dmem_addr[12:2]` and `dmem_wdata`, then go to ISSUE.
- **ISSUE:** drive `mem_cs`=1 and `mem_we` = latched wen for this one cycle only. Load the wait counter with WAIT_STATES.
  - If WAIT_STATES > 0, go to WAIT.
  - If WAIT_STATES = 0: a read goes to CAPT, a write goes to DONE.
- **WAIT:** decrement the counter each cycle. When it reaches 1, go to CAPT for a read or DONE for a write. WAIT lasts exactly WAIT_STATES cycles.
- **CAPT:** register `mem_rdata` into `dmem_rdata` at the end of the cycle, then go to DONE.
- **DONE:** `dmem_ready`=1 for one cycle.
  - If `dmem_en`=0, go to IDLE.
  - Otherwise go to HOLD.
- **HOLD:** wait for `dmem_en`=0, then go to IDLE. A request level that is still held after completion never re-issues. A new access needs `dmem_en` low for at least one cycle.
- Inputs other than `dmem_en` are ignored after the IDLE sample. Changing `dmem_addr` mid-access has no effect.
- A write never modifies `dmem_rdata`.
- Reset, or the reset value on every output: state IDLE, counter 0, and all outputs 0. This includes `dmem_rdata`, `mem_addr` and `mem_wdata`.
- Reset asserted mid-access aborts the access at that edge: no `dmem_ready` pulse, and `mem_cs` is 0 from the next cycle. An SRAM write already strobed is not undone.

## Timing
- `dmem_en` is sampled high in cycle 0, so `mem_cs` is high in cycle 1 (T=1).
- Read: `mem_rdata` is valid in cycle 2+W. `dmem_ready` and the new `dmem_rdata` appear in cycle 3+W. With W=1 that is cycle 4.
- Write: `dmem_ready` appears in cycle 2+W. With W=1 that is cycle 3.
- Back-to-back: the next request can be sampled at the earliest in the cycle after DONE, provided `dmem_en` was low in the DONE cycle.
- There are no combinational paths from inputs to outputs.

## Configuration
- The alignment check is controlled by the macro `DMEM_BRIDGE_ALIGN_CHECK_EN`.
- **Defined:**
  - In IDLE, a request is misaligned if it is a word access with `dmem_addr[1:0]`≠0, or a half access with `dmem_addr[0]`≠0.
  - A misaligned request skips ISSUE, WAIT and CAPT and goes straight to DONE, so `dmem_ready`=1 and `dmem_err`=1 in cycle 1.
  - `mem_cs` stays 0 and `dmem_rdata` is unchanged.
- **Undefined:** `dmem_err` is tied to 0 and the address low bits are ignored. All requests are issued.

## Test plan
- Reset, then idle for 5 cycles: all outputs are 0 and `mem_cs` never rises.
- W=1, read at `dmem_addr`=0x0010 with the SRAM word 4 = 0xDEADBEEF: `mem_cs` and `mem_addr`=4 in cycle 1, then `dmem_ready` and `dmem_rdata`=0xDEADBEEF in cycle 4.
- W=0, write 0x12345678 to 0x0020: `mem_cs`=`mem_we`=1, `mem_addr`=8 and `mem_wdata`=0x12345678 in cycle 1, then `dmem_ready` in cycle 2. A read back returns 0x12345678.
- `dmem_en` held high for 10 cycles on a read: exactly one `mem_cs` pulse and one `dmem_ready` pulse. After `dmem_en` drops for one cycle, a second request issues normally.
- W=3, `rst` pulsed in cycle 3 of a read: no `dmem_ready`, and all outputs are 0 the cycle after reset. A following read completes with W=3 latency (ready in cycle 6).
- With `DMEM_BRIDGE_ALIGN_CHECK_EN` defined, a word read at 0x0006: `dmem_ready`=`dmem_err`=1 in cycle 1 with no `mem_cs`. A half read at 0x0006 completes normally with `dmem_err`=0.
